uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised successor to the fixed 8N1 UART transmit controller. It drives one serial frame per request: start bit, DATA_W data bits LSB-first, optional even/odd parity, and one or two stop bits. An RTS/CTS handshake is applied before every frame, and a baud divider is restarted per frame. It sits between the host write interface and the tx pin, replacing the hard-wired 11-count down-counter scheme.

Parameters:
DATA_W, 8, data bits per frame (5..9 legal).
CLKS_PER_BAUD, 10, CLK cycles per serial bit (>=2).

Ports:
CLK  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  block enable; gates new requests
tx_start  in  1  request pulse/level; sampled only in IDLE
tx_data  in  DATA_W  frame payload, latched on accept
par_mode  in  2  00 none, 01 even, 10 odd, 11 none; latched on accept
two_stop  in  1  1 = two stop bits; latched on accept
CTS  in  1  clear-to-send from receiver
RTS  out  1  request-to-send
tx  out  1  serial line, idle high
busy  out  1  high in any state except IDLE
baud_tick  out  1  one-cycle pulse at the end of each bit period
done  out  1  one-cycle pulse after the final stop bit

Behaviour:
- One clock and one reset: CLK, with rst synchronous and active-high.
- Reset values: tx=1, RTS=0, busy=0, done=0, baud_tick=0, state=IDLE, divider=0, bit counter=0. Reset in any state, including mid-frame, forces IDLE on the next edge; the partial frame is dropped.
- FSM states: IDLE, REQ, START, DATA, PARITY, STOP, DONE.
- IDLE: if en & tx_start, latch tx_data, par_mode and two_stop, then go to REQ. RTS=1 from the next cycle.
- REQ: RTS=1, tx=1.
  - CTS=1 sampled goes to START; the divider clears and tx=0 from the next cycle.
  - en=0 sampled aborts to IDLE with RTS=0 next cycle; this takes priority over CTS.
  - CTS low holds REQ indefinitely.
- Divider: counts 0..CLKS_PER_BAUD-1. baud_tick=1 when the count equals CLKS_PER_BAUD-1. Every bit therefore lasts exactly CLKS_PER_BAUD cycles.
- START: tx=0 for one bit, then DATA.
- DATA: tx = shreg[0]; shift right on each baud_tick. Bit counter runs 0..DATA_W-1. After the last bit go to PARITY if the mode is even/odd, else STOP.
- PARITY: even mode sends XOR of latched data; odd mode sends its inverse. Lasts one bit.
- STOP: tx=1 for 1 bit, or 2 bits when two_stop was latched.
- DONE: one cycle with done=1 and RTS still 1; next cycle IDLE with RTS=0.
- Frame length is (1 + DATA_W + P + S) * CLKS_PER_BAUD cycles, where P is 0/1 and S is 1/2.
- Latency: CTS high sampled at cycle M puts the start bit on tx at M+1. done asserts the cycle after the last stop bit's final cycle.
- Mid-frame events:
  - CTS falling mid-frame is ignored; the frame completes.
  - en falling mid-frame is ignored; the frame completes.
  - tx_start while busy is ignored and not queued.
  - tx_data and par_mode changes while busy have no effect.
- Back-to-back: tx_start held high with en=1 is accepted again in the IDLE cycle after DONE.
- tx is registered with no combinational path from inputs. baud_tick is low in IDLE and REQ.

Decomposition:
- Package uart_tx_pkg holds:
  - state_t enum (IDLE, REQ, START, DATA, PARITY, STOP, DONE);
  - par_mode constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
  - the function frame_bits(data_w, par_en, two_stop).
- One sub-module, uart_baud_gen: parameter CLKS_PER_BAUD, synchronous clear input, emits tick. It replaces the separate baud down-clocker.

Test Plan:
- DATA_W=8, CLKS=10, par=00, two_stop=0, data=0x55, CTS tied high -> tx pattern 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles. Frame is 100 cycles, done is a single pulse, busy falls the cycle after done.
- data=0x07 with par=01 -> parity bit 1, frame 110 cycles. Repeat with par=10 -> parity bit 0. Repeat with par=11 -> no parity bit, 100 cycles.
- two_stop=1, data=0xFF, par=00 -> stop high for 20 cycles, frame 110 cycles.
- CTS held low for 50 cycles after tx_start -> RTS=1, tx=1, busy=1 throughout. CTS rises at cycle M -> tx=0 at M+1.
- en dropped while in REQ -> RTS=0 and busy=0 next cycle, no start bit. en dropped during DATA -> frame completes unchanged.
- rst asserted at bit 4 of a frame -> next cycle tx=1, RTS=0, busy=0. A new tx_start afterwards yields a clean full frame. A tx_start pulse mid-frame produces no second frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// +---------------------------------------------------------------------------+
// | uart_tx_pkg : shared types and constants for the UART transmit engine      |
// | Revision    : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Serial bits in one frame: start + data + optional parity + stop(s).
   function automatic int frame_bits(input int data_w, input logic par_en, input logic two_stop);
      return 1 + data_w + (par_en ? 1 : 0) + (two_stop ? 2 : 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_engine_if.sv
// +---------------------------------------------------------------------------+
// | uart_tx_engine_if : host request / flow-control / line bundle for the TX   |
// | Revision          : 1.0                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_engine_if #(
   parameter int DATA_W = 8
);
   logic              en;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic [1:0]        par_mode;
   logic              two_stop;
   logic              CTS;
   logic              RTS;
   logic              tx;
   logic              busy;
   logic              baud_tick;
   logic              done;

   modport master (
      output en, tx_start, tx_data, par_mode, two_stop, CTS,
      input  RTS, tx, busy, baud_tick, done
   );

   modport slave (
      input  en, tx_start, tx_data, par_mode, two_stop, CTS,
      output RTS, tx, busy, baud_tick, done
   );
endinterface

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// +---------------------------------------------------------------------------+
// | uart_baud_gen : per-frame restartable bit-period divider                   |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_baud_gen #(
   parameter int CLKS_PER_BAUD = 10
) (
   input  wire logic CLK,
   input  wire logic rst,
   input  wire logic i_clr,
   output logic      o_tick
);

   localparam int              c_cw   = $clog2(CLKS_PER_BAUD);
   localparam logic [c_cw-1:0] c_last = c_cw'(CLKS_PER_BAUD - 1);

   logic [c_cw-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (r_cnt == c_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Suppressed while held clear so no tick leaks out in idle/request phases.
   assign o_tick = ~i_clr & (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// +---------------------------------------------------------------------------+
// | uart_tx_engine : parametrised UART transmitter with RTS/CTS handshake      |
// | Revision       : 1.0                                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_tx_engine
   import uart_tx_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int CLKS_PER_BAUD = 10
) (
   input  wire logic       CLK,
   input  wire logic       rst,
   uart_tx_engine_if.slave bus
);

   localparam logic [2:0] c_st_idle   = IDLE;
   localparam logic [2:0] c_st_req    = REQ;
   localparam logic [2:0] c_st_start  = START;
   localparam logic [2:0] c_st_data   = DATA;
   localparam logic [2:0] c_st_parity = PARITY;
   localparam logic [2:0] c_st_stop   = STOP;
   localparam logic [2:0] c_st_done   = DONE;

   localparam int              c_bw       = $clog2(DATA_W);
   localparam logic [c_bw-1:0] c_last_bit = c_bw'(DATA_W - 1);

   logic [2:0]        r_state;
   logic [DATA_W-1:0] r_shreg;
   logic [c_bw-1:0]   r_bit_cnt;
   logic              r_par_en;
   logic              r_par_bit;
   logic              r_two_stop;
   logic              r_stop_cnt;
   logic              r_tx;
   logic              w_tick;
   logic              w_div_clr;

   // Divider only runs while a bit is on the line; it restarts with every start bit.
   assign w_div_clr = (r_state == c_st_idle) || (r_state == c_st_req) || (r_state == c_st_done);

   uart_baud_gen #(
      .CLKS_PER_BAUD(CLKS_PER_BAUD)
   ) u_baud (
      .CLK   (CLK),
      .rst   (rst),
      .i_clr (w_div_clr),
      .o_tick(w_tick)
   );

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_two_stop <= 1'b0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_tx <= 1'b1;
               if (bus.en && bus.tx_start) begin
                  r_shreg    <= bus.tx_data;
                  r_par_en   <= (bus.par_mode == PAR_EVEN) || (bus.par_mode == PAR_ODD);
                  r_par_bit  <= (bus.par_mode == PAR_ODD) ? ~(^bus.tx_data) : ^bus.tx_data;
                  r_two_stop <= bus.two_stop;
                  r_state    <= c_st_req;
               end
            end
            c_st_req: begin
               if (!bus.en) begin
                  r_state <= c_st_idle;
               end else if (bus.CTS) begin
                  r_state <= c_st_start;
                  r_tx    <= 1'b0;
               end
            end
            c_st_start: begin
               if (w_tick) begin
                  r_state   <= c_st_data;
                  r_tx      <= r_shreg[0];
                  r_bit_cnt <= '0;
               end
            end
            c_st_data: begin
               if (w_tick) begin
                  if (r_bit_cnt == c_last_bit) begin
                     r_stop_cnt <= 1'b0;
                     if (r_par_en) begin
                        r_state <= c_st_parity;
                        r_tx    <= r_par_bit;
                     end else begin
                        r_state <= c_st_stop;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_shreg   <= r_shreg >> 1;
                     r_tx      <= r_shreg[1];
                  end
               end
            end
            c_st_parity: begin
               if (w_tick) begin
                  r_state    <= c_st_stop;
                  r_tx       <= 1'b1;
                  r_stop_cnt <= 1'b0;
               end
            end
            c_st_stop: begin
               if (w_tick) begin
                  if (r_two_stop && !r_stop_cnt) begin
                     r_stop_cnt <= 1'b1;
                  end else begin
                     r_state <= c_st_done;
                  end
               end
            end
            c_st_done: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign bus.tx        = r_tx;
   assign bus.busy      = (r_state != c_st_idle);
   assign bus.RTS       = (r_state != c_st_idle);
   assign bus.done      = (r_state == c_st_done);
   assign bus.baud_tick = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
// +---------------------------------------------------------------------------+
// | tb_uart_tx_engine : directed self-checking bench for uart_tx_engine        |
// | Revision          : 1.0                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_engine;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   uart_tx_engine_if #(.DATA_W(8)) bus ();

   uart_tx_engine #(
      .DATA_W       (8),
      .CLKS_PER_BAUD(10)
   ) dut (
      .CLK(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   // disturb: 0 none, 1 drop en mid-frame, 2 tx_start pulse mid-frame, 3 CTS low mid-frame
   task automatic send(input string tag, input logic [7:0] d, input logic [1:0] pm,
                       input logic ts, input logic [10:0] exp_bits, input int exp_n,
                       input int disturb);
      logic [10:0] got;
      int          t;
      int          ticks;
      bit          seen;
      got   = '0;
      ticks = 0;
      @(posedge clk); #1;
      bus.tx_data  = d;
      bus.par_mode = pm;
      bus.two_stop = ts;
      bus.tx_start = 1'b1;
      @(posedge clk); #1;
      bus.tx_start = 1'b0;
      bus.tx_data  = ~d;
      bus.par_mode = ~pm;
      bus.two_stop = ~ts;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.tx == 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, " start"}, 32'(seen), 32'd1);
      if (!seen) return;
      t = 0;
      while (t < 300) begin
         if ((t % 10 == 5) && (t / 10 < 11)) got[t/10] = bus.tx;
         if (bus.baud_tick) ticks++;
         if (bus.done) break;
         if (t == 40) begin
            case (disturb)
               1: bus.en       = 1'b0;
               2: bus.tx_start = 1'b1;
               3: bus.CTS      = 1'b0;
               default: ;
            endcase
         end
         if (t == 41 && disturb == 2) bus.tx_start = 1'b0;
         t++;
         @(negedge clk);
      end
      check({tag, " len"}, 32'(t), 32'(exp_n * 10));
      check({tag, " bits"}, 32'(got), 32'(exp_bits));
      check({tag, " ticks"}, 32'(ticks), 32'(exp_n));
      check({tag, " done_rts_busy"}, {29'd0, bus.done, bus.RTS, bus.busy}, 32'b111);
      @(negedge clk);
      check({tag, " after"}, {28'd0, bus.done, bus.busy, bus.RTS, bus.tx}, 32'b0001);
      bus.en  = 1'b1;
      bus.CTS = 1'b1;
   endtask

   initial begin
      bit bad;
      int gap;
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.en       = 1'b1;
      bus.tx_start = 1'b0;
      bus.tx_data  = 8'h00;
      bus.par_mode = 2'b00;
      bus.two_stop = 1'b0;
      bus.CTS      = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset", {27'd0, bus.tx, bus.RTS, bus.busy, bus.done, bus.baud_tick}, 32'b10000);

      // Basic frames: start, LSB-first data, parity, stop(s).
      send("8n1_55",   8'h55, 2'b00, 1'b0, 11'h2AA, 10, 0);
      send("even_07",  8'h07, 2'b01, 1'b0, 11'h60E, 11, 0);
      send("odd_07",   8'h07, 2'b10, 1'b0, 11'h40E, 11, 0);
      send("none11_07",8'h07, 2'b11, 1'b0, 11'h20E, 10, 0);
      send("2stop_ff", 8'hFF, 2'b00, 1'b1, 11'h7FE, 11, 0);
      send("odd_a3",   8'hA3, 2'b10, 1'b0, 11'h746, 11, 0);

      // CTS held low keeps the request pending.
      bus.CTS = 1'b0;
      @(posedge clk); #1 bus.tx_data = 8'h55; bus.par_mode = 2'b00; bus.two_stop = 1'b0; bus.tx_start = 1'b1;
      @(posedge clk); #1 bus.tx_start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("cts_hold", {28'd0, bus.RTS, bus.tx, bus.busy, bus.baud_tick}, 32'b1110);
      end
      @(posedge clk); #1 bus.CTS = 1'b1;
      @(negedge clk);
      check("cts_pre_edge", 32'(bus.tx), 32'd1);
      @(negedge clk);
      check("cts_start_lat", 32'(bus.tx), 32'd0);
      wait_done("cts_drain");
      @(negedge clk);

      // en dropped in REQ aborts without a start bit.
      bus.CTS = 1'b0;
      @(posedge clk); #1 bus.tx_start = 1'b1;
      @(posedge clk); #1 bus.tx_start = 1'b0; bus.en = 1'b0;
      @(negedge clk);
      check("req_pending", {29'd0, bus.RTS, bus.busy, bus.tx}, 32'b111);
      @(negedge clk);
      check("req_abort", {29'd0, bus.RTS, bus.busy, bus.tx}, 32'b001);
      bus.CTS = 1'b1;
      bus.en  = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad = 1'b1;
      end
      check("abort_quiet", 32'(bad), 32'd0);

      // Mid-frame disturbances leave the frame untouched.
      send("en_drop",  8'h55, 2'b00, 1'b0, 11'h2AA, 10, 1);
      send("cts_drop", 8'h07, 2'b01, 1'b0, 11'h60E, 11, 3);
      send("start_pulse", 8'h55, 2'b00, 1'b0, 11'h2AA, 10, 2);
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) bad = 1'b1;
      end
      check("no_requeue", 32'(bad), 32'd0);

      // Reset mid-frame drops the frame; the next one is clean.
      @(posedge clk); #1 bus.tx_data = 8'h55; bus.par_mode = 2'b00; bus.two_stop = 1'b0; bus.tx_start = 1'b1;
      @(posedge clk); #1 bus.tx_start = 1'b0;
      repeat (47) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset", {28'd0, bus.tx, bus.RTS, bus.busy, bus.done}, 32'b1000);
      rst = 1'b0;
      send("post_reset", 8'h55, 2'b00, 1'b0, 11'h2AA, 10, 0);

      // Back-to-back with tx_start held high.
      @(posedge clk); #1 bus.tx_data = 8'h07; bus.par_mode = 2'b00; bus.two_stop = 1'b0; bus.tx_start = 1'b1;
      wait_done("b2b_first");
      gap = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.tx == 1'b0) begin
            gap = i;
            break;
         end
      end
      check("b2b_gap", 32'(gap), 32'd3);
      bus.tx_start = 1'b0;
      wait_done("b2b_second");
      @(negedge clk);
      check("b2b_idle", {30'd0, bus.busy, bus.tx}, 32'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
